// File: rtl/mul_error_profiler.sv
// Error profiler for an approximate multiplier: it drives the operand pairs, compares each product
// with the exact one, and accumulates the error count, error sum, maximum error and overflow count.
module mul_error_profiler #(
    parameter int WIDTH = 16,
    parameter int NS_W  = 16,
    parameter int ACC_W = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [2*WIDTH-1:0]   seed,
    input  logic [NS_W-1:0]      num_samples,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     mul_in1,
    output logic [WIDTH-1:0]     mul_in2,
    input  logic [2*WIDTH:0]     mul_out,
    input  logic                 mul_overflow,
    output logic [NS_W-1:0]      err_count,
    output logic [ACC_W-1:0]     err_sum,
    output logic [2*WIDTH:0]     err_max,
    output logic [WIDTH-1:0]     max_in1,
    output logic [WIDTH-1:0]     max_in2,
    output logic [NS_W-1:0]      ovf_count
);

    // state | meaning
    // IDLE  | waiting for start; results held
    // RUN   | one operand pair presented per cycle
    // DRAIN | last sample still in stage 1
    // FIN   | done pulse, results valid
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam int PW = 2 * WIDTH;
    localparam int EW = PW + 1;
    localparam logic [31:0] TAP32 = 32'h8020_0003;
    localparam logic [31:0] TAP16 = 32'h0000_B400;
    localparam logic [PW-1:0] TAP_MASK = (PW == 32) ? TAP32[PW-1:0] : TAP16[PW-1:0];

    logic [1:0]       state_q, state_d;
    logic [NS_W-1:0]  rem_q, rem_d;
    logic [PW-1:0]    opw_q, opw_d;
    logic             mode_q, mode_d;
    logic             busy_q, done_q;
    logic             clr_stats, s1_load;

    logic             s1_vld_q;
    logic [EW-1:0]    s1_out_q;
    logic [PW-1:0]    s1_exact_q;
    logic             s1_ovf_q;
    logic [WIDTH-1:0] s1_in1_q, s1_in2_q;

    logic [NS_W-1:0]  err_count_q, ovf_count_q;
    logic [ACC_W-1:0] err_sum_q;
    logic [EW-1:0]    err_max_q;
    logic [WIDTH-1:0] max_in1_q, max_in2_q;

    logic [PW-1:0]    seed_load, opw_adv, lfsr_next, exact_prod;
    logic [EW-1:0]    exact_ext, abs_err;
    logic [ACC_W:0]   sum_ext;

    assign mul_in1    = opw_q[PW-1:WIDTH];
    assign mul_in2    = opw_q[WIDTH-1:0];
    assign exact_prod = PW'(mul_in1) * PW'(mul_in2);

    // An all-zero word is a lock-up state for the LFSR.
    assign seed_load = (!mode && seed == '0) ? '1 : seed;
    assign lfsr_next = (opw_q >> 1) ^ (opw_q[0] ? TAP_MASK : '0);
    assign opw_adv   = mode_q ? opw_q + PW'(1) : lfsr_next;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        opw_d     = opw_q;
        mode_d    = mode_q;
        clr_stats = 1'b0;
        s1_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr_stats = 1'b1;
                    mode_d    = mode;
                    if (num_samples == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        opw_d   = seed_load;
                        rem_d   = num_samples;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                s1_load = 1'b1;
                opw_d   = opw_adv;
                rem_d   = rem_q - NS_W'(1);
                if (rem_q == NS_W'(1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_vld_q) state_d = ST_FIN;
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Unsigned magnitude compare gives the same result as the signed difference.
    assign exact_ext = {1'b0, s1_exact_q};
    assign abs_err   = (s1_out_q >= exact_ext) ? s1_out_q - exact_ext : exact_ext - s1_out_q;
    assign sum_ext   = {1'b0, err_sum_q} + (ACC_W + 1)'(abs_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            opw_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            opw_q   <= opw_d;
            mode_q  <= mode_d;
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q  <= (state_d == ST_FIN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_out_q   <= '0;
            s1_exact_q <= '0;
            s1_ovf_q   <= 1'b0;
            s1_in1_q   <= '0;
            s1_in2_q   <= '0;
        end else begin
            s1_vld_q <= s1_load;
            if (s1_load) begin
                s1_out_q   <= mul_out;
                s1_exact_q <= exact_prod;
                s1_ovf_q   <= mul_overflow;
                s1_in1_q   <= mul_in1;
                s1_in2_q   <= mul_in2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
            err_sum_q   <= '0;
            err_max_q   <= '0;
            max_in1_q   <= '0;
            max_in2_q   <= '0;
            ovf_count_q <= '0;
        end else if (clr_stats) begin
            err_count_q <= '0;
            err_sum_q   <= '0;
            err_max_q   <= '0;
            max_in1_q   <= '0;
            max_in2_q   <= '0;
            ovf_count_q <= '0;
        end else if (s1_vld_q) begin
            if (abs_err != '0) err_count_q <= err_count_q + NS_W'(1);
            err_sum_q <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            // Strictly greater so the first sample reaching the maximum is kept.
            if (abs_err > err_max_q) begin
                err_max_q <= abs_err;
                max_in1_q <= s1_in1_q;
                max_in2_q <= s1_in2_q;
            end
            if (s1_ovf_q) ovf_count_q <= ovf_count_q + NS_W'(1);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_count_q;
    assign err_sum   = err_sum_q;
    assign err_max   = err_max_q;
    assign max_in1   = max_in1_q;
    assign max_in2   = max_in2_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_mul_error_profiler.sv
// Self-checking bench for mul_error_profiler: a behavioural multiplier stub plus an arithmetic
// reference model of the run statistics.
module tb_mul_error_profiler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] seed = '0;
    logic [15:0] num_samples = '0;
    logic        busy, done;
    logic [15:0] mul_in1, mul_in2;
    logic [32:0] mul_out;
    logic        mul_overflow;
    logic [15:0] err_count, ovf_count;
    logic [47:0] err_sum;
    logic [32:0] err_max;
    logic [15:0] max_in1, max_in2;

    int          stub_sel = 0;
    int          ovf_sel = 0;
    logic        tgl = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_word = '0;
    logic [31:0] first_w, second_w;

    mul_error_profiler #(.WIDTH(16), .NS_W(16), .ACC_W(48)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
        .num_samples(num_samples), .busy(busy), .done(done),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out), .mul_overflow(mul_overflow),
        .err_count(err_count), .err_sum(err_sum), .err_max(err_max),
        .max_in1(max_in1), .max_in2(max_in2), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // Multiplier stubs under test
    function automatic longint stub_prod(input int sel, input longint a, input longint b);
        longint ex;
        ex = a * b;
        case (sel)
            1:       return ex & ~longint'(1);
            2:       return (ex >= 2) ? ex - 2 : ex;
            3:       return ex + (((a & 7) == 5) ? (b & 255) : 0);
            4:       return ex ^ (((a & 3) << 4) | (b & 15));
            5:       return ((a & b & 1) != 0) ? ex + (longint'(1) << 32) : ex;
            default: return ex;
        endcase
    endfunction

    function automatic logic ovf_stub(input int sel, input logic t, input logic [15:0] a,
                                      input logic [15:0] b);
        case (sel)
            1:       return t;
            2:       return a[3] ^ b[5];
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        mul_out      = 33'(stub_prod(stub_sel, longint'(mul_in1), longint'(mul_in2)));
        mul_overflow = ovf_stub(ovf_sel, tgl, mul_in1, mul_in2);
    end

    // Alternates 0,1,0,... over the samples of a run.
    always @(posedge clk) tgl <= busy ? ~tgl : 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model(input logic md, input logic [31:0] sd, input int n, input int sel,
                         input int osel, output longint e_cnt, output longint e_sum,
                         output longint e_max, output longint m1, output longint m2,
                         output longint o_cnt);
        logic [31:0] w;
        longint a, b, ex, p, err;
        logic ov;
        e_cnt = 0; e_sum = 0; e_max = 0; m1 = 0; m2 = 0; o_cnt = 0;
        w = (n == 0) ? exp_word : ((!md && sd == 0) ? 32'hFFFF_FFFF : sd);
        for (int k = 0; k < n; k++) begin
            a  = longint'(w[31:16]);
            b  = longint'(w[15:0]);
            ex = a * b;
            p  = stub_prod(sel, a, b);
            err = (p > ex) ? p - ex : ex - p;
            if (err != 0) e_cnt++;
            e_sum += err;
            if (err > e_max) begin
                e_max = err; m1 = a; m2 = b;
            end
            ov = ovf_stub(osel, logic'(k % 2), w[31:16], w[15:0]);
            if (ov) o_cnt++;
            if (md) w = w + 32'd1;
            else    w = (w >> 1) ^ (w[0] ? 32'h8020_0003 : 32'h0);
        end
        exp_word = w;
    endtask

    task automatic run(input logic md, input logic [31:0] sd, input int n, input int sel,
                       input int osel, input bit poke, input string tag);
        longint e_cnt, e_sum, e_max, m1, m2, o_cnt;
        int done_cyc;
        bit busy_seen;
        model(md, sd, n, sel, osel, e_cnt, e_sum, e_max, m1, m2, o_cnt);
        stub_sel = sel;
        ovf_sel  = osel;
        @(negedge clk);
        mode = md; seed = sd; num_samples = 16'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~md; seed = $urandom; num_samples = 16'(n + 5);
        done_cyc = 0;
        busy_seen = 1'b0;
        for (int c = 1; c <= n + 20; c++) begin
            if (c == 1) first_w = {mul_in1, mul_in2};
            if (c == 2) second_w = {mul_in1, mul_in2};
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cyc = c;
                break;
            end
            start = (poke && c == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        check({tag, "_done_cyc"}, 64'(done_cyc), (n == 0) ? 64'd1 : 64'(n + 3));
        check({tag, "_busy_seen"}, 64'(busy_seen), 64'(n != 0));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), e_cnt);
        check({tag, "_err_sum"}, 64'(err_sum), e_sum);
        check({tag, "_err_max"}, 64'(err_max), e_max);
        check({tag, "_max_in1"}, 64'(max_in1), m1);
        check({tag, "_max_in2"}, 64'(max_in2), m2);
        check({tag, "_ovf_count"}, 64'(ovf_count), o_cnt);
        check({tag, "_operands"}, 64'({mul_in1, mul_in2}), 64'(exp_word));
        // A start landing in the done cycle must be ignored.
        start = poke;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int dcount;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stats", 64'({err_count, ovf_count, err_max[15:0]}), 64'd0);
        check("rst_operands", 64'({mul_in1, mul_in2}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b1, 32'h0000_FFFE, 4, 0, 0, 1'b0, "exact");
        check("exact_first_word", 64'(first_w), 64'h0000_FFFE);
        check("exact_second_word", 64'(second_w), 64'h0000_FFFF);

        run(1'b1, 32'h0000_FFFF, 3, 1, 0, 1'b0, "bit0");
        check("bit0_const_max", 64'({err_count, err_sum[15:0], err_max[15:0], max_in1, max_in2}),
              64'h0001_0001_0001_0001 << 16 | 64'h1);

        run(1'b1, 32'h0003_0003, 2, 2, 0, 1'b0, "minus2");
        check("minus2_const", 64'({err_count, err_sum[15:0], err_max[15:0], max_in1}),
              64'h0002_0004_0002_0003);

        run(1'b0, 32'h1234_5678, 0, 0, 0, 1'b1, "n0");
        run(1'b1, 32'h0000_0010, 12, 3, 2, 1'b1, "midstart");

        run(1'b0, 32'h0, 10, 0, 1, 1'b0, "lfsr");
        check("lfsr_first_word", 64'(first_w), 64'hFFFF_FFFF);
        check("lfsr_second_word", 64'(second_w), 64'hFFDF_FFFC);
        check("lfsr_ovf5", 64'(ovf_count), 64'd5);

        // Asynchronous reset in the middle of a run
        stub_sel = 2; ovf_sel = 2;
        @(negedge clk);
        mode = 1'b1; seed = 32'h0003_0003; num_samples = 16'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_errs_nonzero", 64'(err_count != 0), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_operands", 64'({mul_in1, mul_in2}), 64'd0);
        check("arst_stats", 64'({err_count, ovf_count, err_sum[31:0]}), 64'd0);
        check("arst_max", 64'({err_max, max_in1, max_in2}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_word = '0;
        dcount = 0;
        for (int c = 0; c < 30; c++) begin
            if (done || busy) dcount++;
            @(negedge clk);
        end
        check("arst_no_done", 64'(dcount), 64'd0);

        run(1'b1, 32'h0003_0003, 2, 2, 0, 1'b0, "after_rst");

        for (int i = 0; i < 8; i++) begin
            logic        md;
            logic [31:0] sd;
            int          n, sel;
            md  = 1'($urandom_range(0, 1));
            sd  = (i == 3) ? 32'h0 : $urandom;
            n   = $urandom_range(1, 40);
            case ($urandom_range(0, 3))
                0:       sel = 0;
                1:       sel = 3;
                2:       sel = 4;
                default: sel = 5;
            endcase
            run(md, sd, n, sel, $urandom_range(0, 2), bit'(i % 2), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 ns");
        $fatal(1);
    end

endmodule
